piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter; the sending end of the 4-bit serial link whose receiver is the SIPO.
//  Accepts WIDTH-bit words over a valid/ready load handshake and emits them one bit per enabled clock on sdo.
//  A one-word holding register allows gap-free back-to-back frames.
//  Default MSB-first order lets a left-shifting SIPO sampling sdo every cycle hold the original word after WIDTH bits.
// PARAMETERS
//  WIDTH      4   word length in bits; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk           input   1      system clock; all state updates on rising edge
//  reset_n       input   1      asynchronous, active-low reset
//  pdi           input   WIDTH  parallel data in; sampled on a load handshake
//  load_valid    input   1      pdi holds a word to send
//  load_ready    output  1      block can accept a word this cycle
//  shift_en      input   1      bit-rate enable; the current bit is consumed on cycles where it is 1
//  sdo           output  1      serial data out
//  sdo_valid     output  1      sdo carries a frame bit
//  sdo_first     output  1      sdo is the first bit of a frame
//  sdo_last      output  1      sdo is the last bit of a frame
//  busy          output  1      frame in progress or word held
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, shreg=0, hold=0, hold_full=0, bit_cnt=0.
//   Outputs during and after reset: sdo=0, sdo_valid=0, sdo_first=0, sdo_last=0, busy=0, load_ready=1.
//   Reset mid-frame aborts the frame; shifting and held words are discarded.
//  Handshake: a word is accepted at a rising edge where load_valid && load_ready.
//   load_ready = !hold_full (combinational, no dependency on load_valid).
//   pdi may change freely when no handshake occurs.
//  State machine:
//   IDLE:  accept -> shreg<=pdi, bit_cnt<=0, go to SHIFT.
//   SHIFT: on shift_en, bit_cnt<=bit_cnt+1 and shreg shifts toward the output end.
//          On shift_en with bit_cnt==WIDTH-1 (last bit consumed):
//            hold_full          -> shreg<=hold, hold_full<=0, bit_cnt<=0, stay in SHIFT
//            else if accept     -> shreg<=pdi, bit_cnt<=0, stay in SHIFT
//            else               -> go to IDLE, bit_cnt<=0
//          Accept in SHIFT, when shreg is not being freed in the same cycle -> hold<=pdi, hold_full<=1.
//  Simultaneous events:
//   - Last bit consumed, hold_full=1, load_valid=1: load_ready=0, no accept; hold moves to shreg.
//     The pending word is accepted next cycle into hold.
//   - shift_en=0 freezes sdo, bit_cnt and state; handshakes still work while hold is empty.
//  Outputs (decoded from registered state, no combinational path from inputs):
//   sdo       = shreg[WIDTH-1] if MSB_FIRST else shreg[0]; forced 0 when !sdo_valid
//   sdo_valid = (state==SHIFT)
//   sdo_first = sdo_valid && bit_cnt==0
//   sdo_last  = sdo_valid && bit_cnt==WIDTH-1
//   busy      = sdo_valid || hold_full
//  Latency: word accepted at edge N in IDLE -> first bit on sdo from edge N.
//   Each bit is held until consumed by a shift_en cycle.
//   With shift_en=1 constantly, a frame lasts WIDTH cycles and back-to-back words have no idle gap.
//  Widths: bit_cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.
//   Vacated shreg positions fill with 0.
// TESTING
//  T1 reset: reset_n=0 mid-frame -> sdo=0, sdo_valid=0, busy=0, load_ready=1 immediately, without waiting for a clock edge.
//  T2 single word: WIDTH=4, MSB_FIRST=1, pdi=4'b1011, shift_en=1 -> sdo 1,0,1,1 on 4 consecutive cycles.
//     sdo_first on cycle 1 and sdo_last on cycle 4; a SIPO sampling sdo reads 4'b1011 after cycle 4.
//  T3 LSB-first: MSB_FIRST=0, pdi=4'b1011 -> sdo 1,1,0,1.
//  T4 back-to-back: send 4'hA then 4'h5 and hold 4'hC pending, shift_en=1 -> 8 contiguous valid bits 1010_0101.
//     load_ready=0 while hold is full; 4'hC is accepted when hold frees and follows without a gap.
//  T5 pacing: shift_en=1 every 3rd cycle, pdi=4'h9 -> each bit held 3 cycles; frame ends after 12 cycles; sdo stable in between.
//  T6 edge concurrency: last bit consumed with hold empty and load_valid=1, pdi=4'h6 -> accepted directly.
//     sdo_first=1 next cycle with sdo=0 (MSB of 4'h6); no IDLE cycle in between.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with a one-word holding register.
// Words arrive over a valid/ready handshake. Each word is shifted out on sdo,
// one bit per cycle in which shift_en is high. The holding register lets the
// next word follow the current frame without an idle cycle.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pdi,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_first,
    output logic             sdo_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             accept_s;

    // Move the register one position toward the output end; the vacated end fills with 0.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Accept a word whenever the holding slot is empty. This does not depend on load_valid timing.
    always_comb begin
        load_ready = ~hold_full_q;
        accept_s   = load_valid & ~hold_full_q;
    end

    // Next-state logic for the frame sequencer, the shift register and the holding slot.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shreg_d   = pdi;
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en && (bit_cnt_q == LAST_IDX)) begin
                    // Last bit consumed: reload from the holding slot first, else take a new word directly.
                    bit_cnt_d = {CW{1'b0}};
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        shreg_d = pdi;
                    end else begin
                        shreg_d = shift_out(shreg_q);
                        state_d = IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        shreg_d   = shift_out(shreg_q);
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else begin
                        shreg_d = shreg_q;
                    end
                    if (accept_s) begin
                        hold_d      = pdi;
                        hold_full_d = 1'b1;
                    end else begin
                        hold_full_d = hold_full_q;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                shreg_d     = {WIDTH{1'b0}};
                hold_full_d = 1'b0;
                bit_cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State registers; an asynchronous reset aborts any frame and discards held data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= {WIDTH{1'b0}};
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            bit_cnt_q   <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    // Serial outputs are decoded purely from registered state.
    always_comb begin
        sdo_valid = (state_q == SHIFT);
        if (sdo_valid) begin
            sdo = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end else begin
            sdo = 1'b0;
        end
        sdo_first = sdo_valid & (bit_cnt_q == {CW{1'b0}});
        sdo_last  = sdo_valid & (bit_cnt_q == LAST_IDX);
        busy      = sdo_valid | hold_full_q;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: an MSB-first and an LSB-first instance share the same
// stimulus. Both are checked against a word-queue reference model and against
// directed scenarios.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] pdi;
    logic       load_valid;
    logic       shift_en;
    logic       m_ready, m_sdo, m_valid, m_first, m_last, m_busy;
    logic       l_ready, l_sdo, l_valid, l_first, l_last, l_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: words accepted but not yet fully sent (at most 2), and bit position in the front word.
    logic [3:0] mq[$];
    int         mpos = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .pdi(pdi), .load_valid(load_valid), .load_ready(m_ready),
        .shift_en(shift_en), .sdo(m_sdo), .sdo_valid(m_valid), .sdo_first(m_first),
        .sdo_last(m_last), .busy(m_busy)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .pdi(pdi), .load_valid(load_valid), .load_ready(l_ready),
        .shift_en(shift_en), .sdo(l_sdo), .sdo_valid(l_valid), .sdo_first(l_first),
        .sdo_last(l_last), .busy(l_busy)
    );

    function automatic logic exp_bit(input bit msb);
        logic [3:0] w;
        if (mq.size() == 0) return 1'b0;
        w = mq[0];
        return msb ? w[3 - mpos] : w[mpos];
    endfunction

    // Expected {valid, first, last, busy, ready, sdo}
    function automatic logic [5:0] exp_vec(input bit msb);
        logic v;
        v = (mq.size() > 0);
        return {v, v && (mpos == 0), v && (mpos == 3), v, (mq.size() < 2), exp_bit(msb)};
    endfunction

    // Apply inputs for one cycle (called at a negedge), advance the model at the posedge, return at the next negedge.
    task automatic tick(input logic lv, input logic [3:0] d, input logic se);
        bit acc;
        bit cons;
        load_valid = lv;
        pdi        = d;
        shift_en   = se;
        acc  = lv && (mq.size() < 2);
        cons = se && (mq.size() > 0);
        @(posedge clk);
        if (cons) begin
            mpos++;
            if (mpos == 4) begin
                void'(mq.pop_front());
                mpos = 0;
            end
        end
        if (acc) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_valid = 1'b0; shift_en = 1'b0; pdi = 4'h0;
        #3;
        tests_run++;
        if ({m_sdo, m_valid, m_first, m_last, m_busy, m_ready} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL reset_initial: got %b expected %b", {m_sdo, m_valid, m_first, m_last, m_busy, m_ready}, 6'b000001);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1, 4'hF, 1'b1);
        tick(1'b1, 4'h3, 1'b1);
        tests_run++;
        if ({m_valid, m_busy, m_ready} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_preframe: got %b expected %b", {m_valid, m_busy, m_ready}, 3'b110);
        end
        // Assert reset between clock edges, mid-frame with a held word.
        #2;
        reset_n = 1'b0; load_valid = 1'b0;
        #1;
        tests_run++;
        if ({m_sdo, m_valid, m_busy, m_ready, l_sdo, l_valid, l_busy, l_ready} !== 8'b0001_0001) begin
            tests_failed++;
            $display("FAIL reset_async: got %b expected %b",
                     {m_sdo, m_valid, m_busy, m_ready, l_sdo, l_valid, l_busy, l_ready}, 8'b0001_0001);
        end
        mq.delete();
        mpos = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0, 4'h0, 1'b1);
        tests_run++;
        if ({m_valid, m_busy, m_ready, m_first, m_last} !== 5'b00100) begin
            tests_failed++;
            $display("FAIL reset_after: got %b expected %b", {m_valid, m_busy, m_ready, m_first, m_last}, 5'b00100);
        end
    endtask

    task automatic test_single_word();
        logic [3:0] w;
        logic [3:0] sipo;
        w    = 4'b1011;
        sipo = 4'h0;
        tick(1'b1, w, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({m_valid, m_sdo, l_sdo, m_first, m_last} !== {1'b1, w[3 - i], w[i], (i == 0), (i == 3)}) begin
                tests_failed++;
                $display("FAIL single_word bit%0d: got %b expected %b", i,
                         {m_valid, m_sdo, l_sdo, m_first, m_last}, {1'b1, w[3 - i], w[i], (i == 0), (i == 3)});
            end
            sipo = {sipo[2:0], m_sdo};
            tick(1'b0, 4'h0, 1'b1);
        end
        tests_run++;
        if ({sipo, m_valid} !== {4'b1011, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_word_sipo: got %b expected %b", {sipo, m_valid}, {4'b1011, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] stream;
        logic [3:0]  to_send[$];
        logic        exp_rdy;
        stream = 12'b1010_0101_1100;
        tick(1'b1, 4'hA, 1'b1);
        to_send.push_back(4'h5);
        to_send.push_back(4'hC);
        for (int i = 0; i < 12; i++) begin
            exp_rdy = (i == 0) || (i == 4) || (i >= 8);
            tests_run++;
            if ({m_valid, m_sdo, m_ready} !== {1'b1, stream[11 - i], exp_rdy}) begin
                tests_failed++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", i,
                         {m_valid, m_sdo, m_ready}, {1'b1, stream[11 - i], exp_rdy});
            end
            if (to_send.size() > 0) begin
                if (mq.size() < 2) begin
                    tick(1'b1, to_send.pop_front(), 1'b1);
                end else begin
                    tick(1'b1, to_send[0], 1'b1);
                end
            end else begin
                tick(1'b0, 4'h0, 1'b1);
            end
        end
        tests_run++;
        if ({m_valid, m_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL back_to_back_end: got %b expected %b", {m_valid, m_busy}, 2'b00);
        end
    endtask

    task automatic test_pacing();
        logic [3:0] w;
        w = 4'h9;
        tick(1'b1, w, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tests_run++;
            if ({m_valid, m_sdo, m_first, m_last} !== {1'b1, w[3 - c / 3], (c < 3), (c >= 9)}) begin
                tests_failed++;
                $display("FAIL pacing cyc%0d: got %b expected %b", c,
                         {m_valid, m_sdo, m_first, m_last}, {1'b1, w[3 - c / 3], (c < 3), (c >= 9)});
            end
            tick(1'b0, 4'h0, (c % 3 == 2));
        end
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pacing_end: got %b expected %b", m_valid, 1'b0);
        end
    endtask

    task automatic test_edge_concurrency();
        tick(1'b1, 4'hE, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) tick(1'b1, 4'h6, 1'b1);
            else        tick(1'b0, 4'h0, 1'b1);
        end
        tests_run++;
        if ({m_valid, m_first, m_sdo, l_sdo, m_ready} !== 5'b11001) begin
            tests_failed++;
            $display("FAIL edge_concurrency: got %b expected %b", {m_valid, m_first, m_sdo, l_sdo, m_ready}, 5'b11001);
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 4'h0, 1'b1);
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_concurrency_end: got %b expected %b", m_valid, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [5:0] em;
        logic [5:0] el;
        for (int n = 0; n < 400; n++) begin
            em = exp_vec(1'b1);
            el = exp_vec(1'b0);
            tests_run++;
            if ({m_valid, m_first, m_last, m_busy, m_ready, m_sdo} !== em) begin
                tests_failed++;
                $display("FAIL random_msb cyc%0d: got %b expected %b", n,
                         {m_valid, m_first, m_last, m_busy, m_ready, m_sdo}, em);
            end
            tests_run++;
            if ({l_valid, l_first, l_last, l_busy, l_ready, l_sdo} !== el) begin
                tests_failed++;
                $display("FAIL random_lsb cyc%0d: got %b expected %b", n,
                         {l_valid, l_first, l_last, l_busy, l_ready, l_sdo}, el);
            end
            tick(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 4'h0, 1'b1);
        tests_run++;
        if ({m_valid, m_busy, l_valid, l_busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL random_drain: got %b expected %b", {m_valid, m_busy, l_valid, l_busy}, 4'b0000);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_pacing();
        test_edge_concurrency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
